// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared line-state encoding for the serial framer and deserializer
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } frame_state_e;

endpackage

// File: rtl/serial_hold_buf.sv
// rtl/serial_hold_buf.sv - 1-entry holding register with valid/ready accept logic
module serial_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full
);

  assign load_ready = !full;

  // Accept and pop never coincide: pop is only issued while full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full     <= 1'b0;
      data_out <= '0;
    end else if (load_valid && load_ready) begin
      full     <= 1'b1;
      data_out <= data_in;
    end else if (pop) begin
      full     <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_framer.sv
// rtl/serial_framer.sv - parallel-to-serial framer: start, LSB-first data, optional even parity, stop
module serial_framer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  frame_state_e     state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             parity_q;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             load_frame;
  logic             line_nxt;
  logic             shift_en;

  serial_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .pop        (load_frame),
    .data_out   (hold_data),
    .full       (hold_full)
  );

  always_comb begin
    state_nxt  = state;
    load_frame = 1'b0;
    line_nxt   = 1'b0;
    shift_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (hold_full) begin
          state_nxt  = START;
          load_frame = 1'b1;
        end
      end
      START:  state_nxt = DATA;
      DATA: begin
        if (bit_cnt == LAST_BIT) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        else                     shift_en  = 1'b1;
      end
      PARITY: state_nxt = STOP;
      STOP: begin
        if (hold_full) begin
          state_nxt  = START;
          load_frame = 1'b1;
        end else begin
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // serial_out is registered, so the line level is chosen from the state being entered.
    unique case (state_nxt)
      START:   line_nxt = 1'b1;
      DATA:    line_nxt = (state == DATA) ? shreg[1] : shreg[0];
      PARITY:  line_nxt = parity_q;
      default: line_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_q   <= 1'b0;
      serial_out <= 1'b0;
    end else begin
      state      <= state_nxt;
      serial_out <= line_nxt;
      bit_cnt    <= shift_en ? bit_cnt + 1'b1 : '0;
      if (load_frame) begin
        shreg    <= hold_data;
        parity_q <= ^hold_data;
      end else if (shift_en) begin
        shreg    <= shreg >> 1;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP);

endmodule

// File: doc/serial_framer.md
SERIAL_FRAMER -- requirements
Module: serial_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning payload bits per word (legal range 2..16).
REQ-002 SHALL have parameter PARITY_EN, default 1, meaning 1 inserts an even-parity bit and 0 omits it.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_in  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port load_valid  input  1  data_in is valid this cycle.
REQ-007 SHALL have port load_ready  output  1  the holding buffer is empty, so a word can be accepted.
REQ-008 SHALL have port serial_out  output  1  registered serial line; it drives shift_in of the downstream 4-bit shift register.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse during the STOP bit cycle.

Function
REQ-011 SHALL accept a word on a rising edge where load_valid=1 and load_ready=1, capturing data_in into a 1-entry holding register (hold_full<=1).
REQ-012 SHALL drive load_ready = !hold_full combinationally; a word is never accepted while hold_full=1.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, with one line bit per clock cycle.
REQ-014 SHALL keep the idle line level at 0: serial_out=0 in IDLE.
REQ-015 SHALL transition IDLE->START on the edge after hold_full becomes 1, so serial_out=1 begins exactly one cycle after the accept edge.
REQ-016 SHALL move the holding register into the shift register and clear hold_full on every edge entering START.
REQ-017 SHALL hold serial_out=1 for one cycle in START, then move to DATA.
REQ-018 SHALL output WIDTH data bits LSB first in DATA, one per cycle, using a bit counter that counts 0..WIDTH-1.
REQ-019 SHALL go from DATA to PARITY when PARITY_EN=1, or directly to STOP when PARITY_EN=0.
REQ-020 SHALL output in PARITY the XOR of all WIDTH data bits (even parity).
REQ-021 SHALL output serial_out=0 in STOP for one cycle, with frame_done=1 in the same cycle.
REQ-022 SHALL go from STOP to START when hold_full=1 (back-to-back, no idle gap), otherwise to IDLE.
REQ-023 SHALL have a frame length of 2+WIDTH+PARITY_EN cycles, which is 11 for the defaults; sustained throughput is one word per frame length.
REQ-024 SHALL allow a new accept in the same cycle as any non-IDLE state; the shift-register contents of the in-flight frame are never disturbed by an accept.
REQ-025 SHALL keep data_in changes while load_ready=0 without effect.

Reset
REQ-026 SHALL, on reset assertion at any time including mid-frame, immediately force: state=IDLE, hold_full=0, bit counter=0, shift register=0, serial_out=0, busy=0, frame_done=0, load_ready=1.
REQ-027 SHALL discard any in-flight frame or held word on reset, with no partial frame resumed after reset release.
REQ-028 SHALL allow the first accept on the first rising edge after reset deassertion.

Structure
REQ-029 SHALL place the FSM state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) in a shared package, serial_pkg, for reuse by the matching deserializer.
REQ-030 SHALL use one sub-module, serial_hold_buf (the 1-entry holding register with the valid/ready logic); the FSM, counter and shifter remain in serial_framer.

Verification
REQ-031 SHALL verify: reset, then accept 0xA5 at cycle 0 -> serial_out from cycle 1 = 1,1,0,1,0,0,1,0,1,0,0, then 0 idle; frame_done high at cycle 11 only.
REQ-032 SHALL verify: accept 0x01, then 0xFF two cycles later -> load_ready=0 until the second START edge; the second frame's start bit follows the first STOP immediately; 0xFF parity bit=0; 22 contiguous busy cycles.
REQ-033 SHALL verify: PARITY_EN=0, WIDTH=4, accept 0x3 -> 1,1,1,0,0,0 (6-cycle frame), with no parity cycle.
REQ-034 SHALL verify: assert reset during DATA bit 3 of 0xA5 -> serial_out=0 and load_ready=1 asynchronously; after release, accepting 0x5A yields a clean, complete frame.
REQ-035 SHALL verify: load_valid held high continuously with incrementing data -> every word is serialized exactly once in order, with none dropped or duplicated.
REQ-036 SHALL verify: serial_out feeding the 4-bit shift register -> its shift_out equals serial_out delayed by 4 cycles.
